// File: rtl/lpm_fifo_dc_flaggen_if.sv
// Request/status bundle between a FIFO clock domain and its flag generator.
// master drives the count and requests; slave (the flag generator) returns the flags.
interface lpm_fifo_dc_flaggen_if #(
  parameter int unsigned lpm_widthad = 4
);
  logic [lpm_widthad-1:0] usedw_in;
  logic                   wreq;
  logic                   rreq;
  logic                   clr_err;
  logic                   empty;
  logic                   full;
  logic                   almost_empty;
  logic                   almost_full;
  logic                   wreq_ok;
  logic                   rreq_ok;
  logic                   overflow_err;
  logic                   underflow_err;

  modport master (
    output usedw_in, wreq, rreq, clr_err,
    input  empty, full, almost_empty, almost_full, wreq_ok, rreq_ok,
           overflow_err, underflow_err
  );

  modport slave (
    input  usedw_in, wreq, rreq, clr_err,
    output empty, full, almost_empty, almost_full, wreq_ok, rreq_ok,
           overflow_err, underflow_err
  );
endinterface

// File: rtl/lpm_fifo_dc_flaggen.sv
// Per-domain status flags for the dual-clock FIFO: empty state machine, threshold flags,
// overflow/underflow-gated request strobes and sticky error flags.
module lpm_fifo_dc_flaggen #(
  parameter int unsigned lpm_widthad        = 4,
  parameter int unsigned lpm_numwords       = 16,
  parameter string       lpm_mode           = "READ",
  parameter int unsigned full_margin        = 3,
  parameter int unsigned almost_full_value  = 12,
  parameter int unsigned almost_empty_value = 2,
  parameter string       overflow_checking  = "ON",
  parameter string       underflow_checking = "ON"
) (
  input logic                   clock,
  input logic                   aclr,
  lpm_fifo_dc_flaggen_if.slave  bus
);

  localparam bit IsRead  = (lpm_mode == "READ");
  localparam bit OvfGate = (overflow_checking == "ON");
  localparam bit UnfGate = (underflow_checking == "ON");

  localparam int          FullDiff = int'(lpm_numwords) - int'(full_margin);
  localparam logic [31:0] FullThr  = (FullDiff < 0) ? 32'd0 : 32'(FullDiff);

  if (lpm_mode != "READ" && lpm_mode != "WRITE") begin : g_bad_mode
    $fatal(1, "lpm_fifo_dc_flaggen: lpm_mode must be \"READ\" or \"WRITE\"");
  end

  // 01 is NON_EMPTY in READ mode and ONE in WRITE mode; bit 0 always means "not empty".
  typedef enum logic [1:0] {
    StEmpty      = 2'b00,
    StActive     = 2'b01,
    StEmptyWait  = 2'b10,
    StWrNonEmpty = 2'b11
  } state_e;

  state_e      r_state;
  logic        r_lrreq;
  logic        r_full;
  logic        r_almost_full;
  logic        r_almost_empty;
  logic        r_overflow_err;
  logic        r_underflow_err;

  logic [31:0] w_usedw;
  logic        w_empty;
  logic        w_wreq_ok;
  logic        w_rreq_ok;
  logic        w_rd_drain;

  assign w_usedw   = 32'(bus.usedw_in);
  assign w_empty   = ~r_state[0];
  assign w_wreq_ok = OvfGate ? (bus.wreq & ~r_full) : bus.wreq;
  assign w_rreq_ok = UnfGate ? (bus.rreq & ~w_empty) : bus.rreq;

  // Last word leaving: either a lone read at one word, or the second of back-to-back reads.
  assign w_rd_drain = bus.rreq && ((w_usedw == 32'd1 && !r_lrreq) ||
                                   (w_usedw == 32'd2 &&  r_lrreq));

  always_ff @(posedge clock or posedge aclr) begin
    if (aclr) begin
      r_state         <= StEmpty;
      r_lrreq         <= 1'b0;
      r_full          <= 1'b0;
      r_almost_full   <= 1'b0;
      r_almost_empty  <= 1'b1;
      r_overflow_err  <= 1'b0;
      r_underflow_err <= 1'b0;
    end else begin
      r_lrreq        <= w_rreq_ok;
      r_full         <= (w_usedw >= FullThr);
      r_almost_full  <= (w_usedw >= almost_full_value);
      r_almost_empty <= (w_usedw <  almost_empty_value);

      if (bus.clr_err) begin
        r_overflow_err  <= 1'b0;
        r_underflow_err <= 1'b0;
      end else begin
        if (bus.wreq && r_full)  r_overflow_err  <= 1'b1;
        if (bus.rreq && w_empty) r_underflow_err <= 1'b1;
      end

      if (IsRead) begin
        case (r_state)
          StEmpty:     if (w_usedw != 32'd0) r_state <= StActive;
          StActive:    if (w_rd_drain) r_state <= StEmptyWait;
          StEmptyWait: r_state <= (w_usedw > 32'd1) ? StActive : StEmpty;
          default:     r_state <= StEmpty;
        endcase
      end else begin
        case (r_state)
          StEmpty:      if (bus.wreq) r_state <= StActive;
          StActive:     if (!bus.wreq) r_state <= StWrNonEmpty;
          StWrNonEmpty: begin
            if (bus.wreq)                r_state <= StActive;
            else if (w_usedw == 32'd0)   r_state <= StEmpty;
          end
          default:      r_state <= StEmpty;
        endcase
      end
    end
  end

  assign bus.empty         = w_empty;
  assign bus.full          = r_full;
  assign bus.almost_empty  = r_almost_empty;
  assign bus.almost_full   = r_almost_full;
  assign bus.wreq_ok       = w_wreq_ok;
  assign bus.rreq_ok       = w_rreq_ok;
  assign bus.overflow_err  = r_overflow_err;
  assign bus.underflow_err = r_underflow_err;

endmodule

// File: tb/tb_lpm_fifo_dc_flaggen.sv
// Bench for lpm_fifo_dc_flaggen: READ, WRITE and unchecked-READ instances driven from
// vector tables, with expected post-edge flags queued at drive time and popped after the edge.
module tb_lpm_fifo_dc_flaggen;

  typedef struct {
    logic [3:0] u;
    bit w, r, c;
    bit wok, rok;
    bit emp, full, ae, af, ovf, unf;
  } vec_t;

  logic clk;
  logic aclr;

  lpm_fifo_dc_flaggen_if #(.lpm_widthad(4)) ri ();
  lpm_fifo_dc_flaggen_if #(.lpm_widthad(4)) wi ();
  lpm_fifo_dc_flaggen_if #(.lpm_widthad(4)) ui ();

  lpm_fifo_dc_flaggen #(.lpm_mode("READ")) u_rd (
    .clock (clk),
    .aclr  (aclr),
    .bus   (ri)
  );

  lpm_fifo_dc_flaggen #(.lpm_mode("WRITE")) u_wr (
    .clock (clk),
    .aclr  (aclr),
    .bus   (wi)
  );

  lpm_fifo_dc_flaggen #(
    .lpm_mode           ("READ"),
    .overflow_checking  ("OFF"),
    .underflow_checking ("OFF")
  ) u_uf (
    .clock (clk),
    .aclr  (aclr),
    .bus   (ui)
  );

  int   n_checks = 0;
  int   n_errors = 0;
  vec_t sb[$];
  vec_t rd_tab[$];
  vec_t wr_tab[$];
  vec_t uf_tab[$];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got still running want finished");
    $fatal(1);
  end

  function automatic vec_t mk(input int u, input bit w, input bit r, input bit c,
                              input bit wok, input bit rok, input bit emp, input bit full,
                              input bit ae, input bit af, input bit ovf, input bit unf);
    vec_t v;
    v.u = 4'(u); v.w = w; v.r = r; v.c = c; v.wok = wok; v.rok = rok;
    v.emp = emp; v.full = full; v.ae = ae; v.af = af; v.ovf = ovf; v.unf = unf;
    return v;
  endfunction

  task automatic chk(input string name, input logic act, input logic exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %b want %b", name, act, exp);
    end
  endtask

  task automatic drive(input int sel, input vec_t v);
    case (sel)
      0: begin ri.usedw_in = v.u; ri.wreq = v.w; ri.rreq = v.r; ri.clr_err = v.c; end
      1: begin wi.usedw_in = v.u; wi.wreq = v.w; wi.rreq = v.r; wi.clr_err = v.c; end
      default: begin ui.usedw_in = v.u; ui.wreq = v.w; ui.rreq = v.r; ui.clr_err = v.c; end
    endcase
  endtask

  // {empty, full, almost_empty, almost_full, overflow_err, underflow_err, wreq_ok, rreq_ok}
  function automatic logic [7:0] sample(input int sel);
    case (sel)
      0: return {ri.empty, ri.full, ri.almost_empty, ri.almost_full,
                 ri.overflow_err, ri.underflow_err, ri.wreq_ok, ri.rreq_ok};
      1: return {wi.empty, wi.full, wi.almost_empty, wi.almost_full,
                 wi.overflow_err, wi.underflow_err, wi.wreq_ok, wi.rreq_ok};
      default: return {ui.empty, ui.full, ui.almost_empty, ui.almost_full,
                       ui.overflow_err, ui.underflow_err, ui.wreq_ok, ui.rreq_ok};
    endcase
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic run_vec(input int sel, input string tag, input vec_t v);
    logic [7:0] o;
    vec_t       e;
    drive(sel, v);
    #1;
    o = sample(sel);
    chk({tag, ".wreq_ok"}, o[1], v.wok);
    chk({tag, ".rreq_ok"}, o[0], v.rok);
    sb.push_back(v);
    step();
    o = sample(sel);
    if (sb.size() == 0) begin
      chk({tag, ".scoreboard"}, 1'b0, 1'b1);
    end else begin
      e = sb.pop_front();
      chk({tag, ".empty"},         o[7], e.emp);
      chk({tag, ".full"},          o[6], e.full);
      chk({tag, ".almost_empty"},  o[5], e.ae);
      chk({tag, ".almost_full"},   o[4], e.af);
      chk({tag, ".overflow_err"},  o[3], e.ovf);
      chk({tag, ".underflow_err"}, o[2], e.unf);
    end
  endtask

  task automatic check_reset_vals(input string tag);
    logic [7:0] o;
    o = sample(0);
    chk({tag, ".empty"},         o[7], 1'b1);
    chk({tag, ".full"},          o[6], 1'b0);
    chk({tag, ".almost_empty"},  o[5], 1'b1);
    chk({tag, ".almost_full"},   o[4], 1'b0);
    chk({tag, ".overflow_err"},  o[3], 1'b0);
    chk({tag, ".underflow_err"}, o[2], 1'b0);
  endtask

  initial begin
    //                 u  w  r  c  wok rok emp full ae af ovf unf
    rd_tab.push_back(mk(2, 0, 1, 0, 0, 1, 0, 0, 0, 0, 0, 0));
    rd_tab.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0));
    rd_tab.push_back(mk(1, 0, 1, 0, 0, 1, 1, 0, 1, 0, 0, 0)); // lone read at 1 word
    rd_tab.push_back(mk(0, 0, 0, 0, 0, 0, 1, 0, 1, 0, 0, 0));
    rd_tab.push_back(mk(3, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    rd_tab.push_back(mk(3, 0, 1, 0, 0, 1, 0, 0, 0, 0, 0, 0));
    rd_tab.push_back(mk(2, 0, 1, 0, 0, 1, 1, 0, 0, 0, 0, 0)); // back-to-back at 2 words
    rd_tab.push_back(mk(1, 0, 0, 0, 0, 0, 1, 0, 1, 0, 0, 0));
    rd_tab.push_back(mk(0, 0, 1, 0, 0, 0, 1, 0, 1, 0, 0, 1));
    rd_tab.push_back(mk(0, 0, 1, 1, 0, 0, 1, 0, 1, 0, 0, 0));
    rd_tab.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0));
    rd_tab.push_back(mk(1, 0, 1, 0, 0, 1, 1, 0, 1, 0, 0, 0));
    rd_tab.push_back(mk(5, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0)); // EMPTY_WAIT back to NON_EMPTY
    rd_tab.push_back(mk(2, 0, 1, 0, 0, 1, 0, 0, 0, 0, 0, 0));
    rd_tab.push_back(mk(13, 0, 0, 0, 0, 0, 0, 1, 0, 1, 0, 0));
    rd_tab.push_back(mk(13, 1, 0, 0, 0, 0, 0, 1, 0, 1, 1, 0));
    rd_tab.push_back(mk(13, 1, 0, 1, 0, 0, 0, 1, 0, 1, 0, 0));
    rd_tab.push_back(mk(12, 1, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0));
    rd_tab.push_back(mk(12, 1, 0, 0, 1, 0, 0, 0, 0, 1, 1, 0));
    rd_tab.push_back(mk(12, 1, 1, 1, 1, 1, 0, 0, 0, 1, 0, 0));
    for (int i = 0; i < 16; i++) begin
      rd_tab.push_back(mk(i, 0, 0, 0, 0, 0, 0, i >= 13, i < 2, i >= 12, 0, 0));
    end
    rd_tab.push_back(mk(15, 1, 0, 0, 0, 0, 0, 1, 0, 1, 1, 0));

    wr_tab.push_back(mk(0, 1, 0, 0, 1, 0, 0, 0, 1, 0, 0, 0));
    wr_tab.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0));
    wr_tab.push_back(mk(1, 1, 0, 0, 1, 0, 0, 0, 1, 0, 0, 0));
    wr_tab.push_back(mk(2, 1, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0));
    wr_tab.push_back(mk(2, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    wr_tab.push_back(mk(2, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    wr_tab.push_back(mk(0, 0, 0, 0, 0, 0, 1, 0, 1, 0, 0, 0));
    wr_tab.push_back(mk(0, 1, 1, 0, 1, 0, 0, 0, 1, 0, 0, 1));
    wr_tab.push_back(mk(0, 0, 0, 1, 0, 0, 0, 0, 1, 0, 0, 0));
    wr_tab.push_back(mk(0, 0, 0, 0, 0, 0, 1, 0, 1, 0, 0, 0));

    uf_tab.push_back(mk(0, 0, 1, 0, 0, 1, 1, 0, 1, 0, 0, 1));
    uf_tab.push_back(mk(14, 1, 0, 0, 1, 0, 0, 1, 0, 1, 0, 1));
    uf_tab.push_back(mk(14, 1, 0, 0, 1, 0, 0, 1, 0, 1, 1, 1));
    uf_tab.push_back(mk(14, 0, 1, 1, 0, 1, 0, 1, 0, 1, 0, 0));
    uf_tab.push_back(mk(14, 0, 0, 0, 0, 0, 0, 1, 0, 1, 0, 0));

    aclr = 1'b1;
    drive(0, mk(7, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    drive(1, mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    drive(2, mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    repeat (3) step();
    check_reset_vals("reset_hold");
    chk("reset_hold.wr_empty", wi.empty, 1'b1);

    aclr = 1'b0;
    #1;
    chk("release.no_edge_empty", ri.empty, 1'b1);
    step();
    chk("release.empty", ri.empty, 1'b0);
    chk("release.almost_empty", ri.almost_empty, 1'b0);

    for (int i = 0; i < rd_tab.size(); i++) run_vec(0, $sformatf("rd%0d", i), rd_tab[i]);
    for (int i = 0; i < wr_tab.size(); i++) run_vec(1, $sformatf("wr%0d", i), wr_tab[i]);
    for (int i = 0; i < uf_tab.size(); i++) run_vec(2, $sformatf("uf%0d", i), uf_tab[i]);

    // Mid-operation reset must clear flags between clock edges.
    #2;
    aclr = 1'b1;
    #1;
    check_reset_vals("async_reset");
    chk("async_reset.wreq_ok", ri.wreq_ok, 1'b1);
    repeat (2) step();
    check_reset_vals("reset_clocked");

    aclr = 1'b0;
    step();
    chk("post_reset.empty", ri.empty, 1'b0);
    chk("post_reset.full", ri.full, 1'b1);
    chk("post_reset.overflow_err", ri.overflow_err, 1'b0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
